// File: rtl/svm_ovr_classifier.sv
// One-vs-rest linear SVM scorer: a single signed MAC walks bias + N_FEAT weights per class, then a running argmax.
// Latency N_CLASS*(N_FEAT+2) cycles from an accepted start; start and weight writes are honoured only in IDLE.
module svm_ovr_classifier #(
  parameter int N_FEAT    = 9,
  parameter int N_CLASS   = 22,
  parameter int DW        = 16,
  parameter int FRAC      = 8,
  parameter int ACC_W     = 40,
  parameter     INIT_FILE = "",
  localparam int CW       = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
  localparam int IW       = $clog2(N_FEAT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_FEAT*DW-1:0]    feat_in,
  input  logic                    start,
  output logic                    busy,
  output logic                    valid,
  output logic [CW-1:0]           predict,
  output logic signed [ACC_W-1:0] score_max,
  input  logic                    wr_en,
  input  logic [CW-1:0]           wr_class,
  input  logic [IW-1:0]           wr_idx,
  input  logic [DW-1:0]           wr_data
);

  localparam int DEPTH = N_CLASS * (N_FEAT + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int JW    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  typedef enum logic [2:0] {IDLE, BIAS, MAC, CMP, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           c;
  logic [JW-1:0]           j;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] best;
  logic [CW-1:0]           best_idx;
  logic signed [DW-1:0]    feat_q [0:N_FEAT-1];

  // Row c holds N_FEAT weights followed by the bias at column N_FEAT.
  logic [DW-1:0] ram [0:DEPTH-1];

  logic          wr_ok;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  always_comb begin
    wr_ok   = wr_en && (state == IDLE) && (int'(wr_class) < N_CLASS) && (int'(wr_idx) <= N_FEAT);
    wr_addr = AW'(int'(wr_class) * (N_FEAT + 1) + int'(wr_idx));
    rd_addr = AW'(int'(c) * (N_FEAT + 1) + ((state == BIAS) ? N_FEAT : int'(j)));
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      ram[wr_addr] <= wr_data;
  end

  logic signed [DW-1:0]    w_rd;
  logic signed [DW-1:0]    x_cur;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic                    take;

  always_comb begin
    w_rd     = $signed(ram[rd_addr]);
    x_cur    = feat_q[j];
    prod     = (2*DW)'(x_cur) * (2*DW)'(w_rd);
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'(w_rd) <<< FRAC;
    // Strict compare keeps the lower class index on ties.
    take     = (c == '0) || (acc > best);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      predict   <= '0;
      score_max <= '0;
      c         <= '0;
      j         <= '0;
      acc       <= '0;
      best      <= '0;
      best_idx  <= '0;
      for (int k = 0; k < N_FEAT; k++)
        feat_q[k] <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N_FEAT; k++)
              feat_q[k] <= $signed(feat_in[k*DW +: DW]);
            c     <= '0;
            busy  <= 1'b1;
            state <= BIAS;
          end
        end
        BIAS: begin
          acc   <= bias_ext;
          j     <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc + prod_ext;
          if (j == JW'(N_FEAT - 1))
            state <= CMP;
          else
            j <= j + 1'b1;
        end
        CMP: begin
          if (take) begin
            best     <= acc;
            best_idx <= c;
          end
          if (c == CW'(N_CLASS - 1)) begin
            // Outputs are registered here so they appear in the DONE cycle.
            predict   <= take ? c : best_idx;
            score_max <= take ? acc : best;
            valid     <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            c     <= c + 1'b1;
            state <= BIAS;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svm_ovr_classifier.sv
// Bench for svm_ovr_classifier (default configuration) against a plain-arithmetic score/argmax model.
module tb_svm_ovr_classifier;

  localparam int NF = 9;
  localparam int NC = 22;
  localparam int LAT = NC * (NF + 2);

  logic               clk = 1'b0;
  logic               rst;
  logic [NF*16-1:0]   feat_in;
  logic               start;
  logic               busy;
  logic               valid;
  logic [4:0]         predict;
  logic signed [39:0] score_max;
  logic               wr_en;
  logic [4:0]         wr_class;
  logic [3:0]         wr_idx;
  logic [15:0]        wr_data;

  svm_ovr_classifier dut (
    .clk(clk), .rst(rst), .feat_in(feat_in), .start(start), .busy(busy), .valid(valid),
    .predict(predict), .score_max(score_max), .wr_en(wr_en), .wr_class(wr_class),
    .wr_idx(wr_idx), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int     mw [NC][NF+1];
  int     mx [NF];
  int     exp_idx;
  longint exp_score;

  integer             got_pred;
  logic signed [63:0] got_score;
  int                 lat;
  logic               b_first, b_at, v_next;

  logic pend_wr = 1'b0;
  int   pend_c, pend_i, pend_d;

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic model();
    longint s;
    exp_idx = 0;
    exp_score = 0;
    for (int c = 0; c < NC; c++) begin
      s = longint'(mw[c][NF]) * 256;
      for (int k = 0; k < NF; k++)
        s += longint'(mx[k]) * longint'(mw[c][k]);
      if (c == 0 || s > exp_score) begin
        exp_score = s;
        exp_idx = c;
      end
    end
  endtask

  task automatic load_all();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i <= NF; i++) begin
        @(negedge clk);
        wr_en = 1'b1; wr_class = 5'(c); wr_idx = 4'(i); wr_data = 16'(mw[c][i]);
      end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drive_feat();
    for (int k = 0; k < NF; k++)
      feat_in[k*16 +: 16] = mx[k][15:0];
  endtask

  task automatic run_job();
    @(negedge clk);
    drive_feat();
    start = 1'b1;
    if (pend_wr) begin
      wr_en = 1'b1; wr_class = 5'(pend_c); wr_idx = 4'(pend_i); wr_data = 16'(pend_d);
      pend_wr = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    b_first = busy;
    lat = 0;
    while (valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    b_at = busy;
    got_pred = predict;
    got_score = score_max;
    @(negedge clk);
    v_next = valid;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; wr_en = 1'b0; feat_in = '0;
    wr_class = '0; wr_idx = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
    tests++; if (predict !== 5'd0) begin fails++; $display("FAIL reset_predict got=%0d exp=0", predict); end
    tests++; if (score_max !== 40'sd0) begin fails++; $display("FAIL reset_score got=%0d exp=0", score_max); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i <= NF; i++)
        mw[c][i] = (i == NF && c >= 3) ? -32768 : 0;
    mw[0][0] = 256; mw[1][1] = 256; mw[2][0] = -256; mw[2][1] = -256;
    for (int k = 0; k < NF; k++) mx[k] = rnd16();
    mx[0] = 512; mx[1] = 768;
    load_all();
    run_job();
    tests++; if (lat !== LAT) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    tests++; if (b_first !== 1'b1) begin fails++; $display("FAIL basic_busy_start got=%b exp=1", b_first); end
    tests++; if (b_at !== 1'b0) begin fails++; $display("FAIL basic_busy_at_valid got=%b exp=0", b_at); end
    tests++; if (v_next !== 1'b0) begin fails++; $display("FAIL basic_valid_pulse got=%b exp=0", v_next); end
    tests++; if (got_pred !== 1) begin fails++; $display("FAIL basic_predict got=%0d exp=1", got_pred); end
    tests++; if (got_score !== 64'sh30000) begin fails++; $display("FAIL basic_score got=%0h exp=30000", got_score); end
    repeat (5) @(negedge clk);
    tests++; if (predict !== 5'd1) begin fails++; $display("FAIL basic_hold_predict got=%0d exp=1", predict); end
    tests++; if (score_max !== 40'sh30000) begin fails++; $display("FAIL basic_hold_score got=%0h exp=30000", score_max); end
  endtask

  task automatic test_bias_neg();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i <= NF; i++)
        mw[c][i] = (i == NF) ? -32768 : 0;
    mw[0][NF] = -128; mw[1][NF] = -64; mw[2][NF] = -256;
    for (int k = 0; k < NF; k++) mx[k] = rnd16();
    load_all();
    run_job();
    tests++; if (got_pred !== 1) begin fails++; $display("FAIL bias_neg_predict got=%0d exp=1", got_pred); end
    tests++; if (got_score !== -64'sd16384) begin fails++; $display("FAIL bias_neg_score got=%0d exp=-16384", got_score); end
  endtask

  task automatic test_tie();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i <= NF; i++)
        mw[c][i] = (i == NF) ? 256 : 0;
    mw[0][NF] = 1280; mw[1][NF] = 1024; mw[2][NF] = 1280;
    for (int k = 0; k < NF; k++) mx[k] = rnd16();
    load_all();
    run_job();
    tests++; if (got_pred !== 0) begin fails++; $display("FAIL tie_predict got=%0d exp=0", got_pred); end
    tests++; if (got_score !== 64'sd327680) begin fails++; $display("FAIL tie_score got=%0d exp=327680", got_score); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < NC; c++)
        for (int i = 0; i <= NF; i++)
          mw[c][i] = rnd16();
      for (int k = 0; k < NF; k++) mx[k] = rnd16();
      load_all();
      // Out-of-range rows/columns must not land anywhere in the RAM.
      for (int n = 0; n < 4; n++) begin
        @(negedge clk);
        wr_en = 1'b1; wr_class = 5'($urandom_range(31, NC)); wr_idx = 4'($urandom_range(NF));
        wr_data = 16'($urandom);
        @(negedge clk);
        wr_class = 5'($urandom_range(NC - 1)); wr_idx = 4'($urandom_range(15, NF + 1));
        wr_data = 16'($urandom);
      end
      @(negedge clk);
      wr_en = 1'b0;
      model();
      run_job();
      tests++; if (got_pred !== exp_idx) begin fails++; $display("FAIL random_predict it=%0d got=%0d exp=%0d", it, got_pred, exp_idx); end
      tests++; if (got_score !== exp_score) begin fails++; $display("FAIL random_score it=%0d got=%0d exp=%0d", it, got_score, exp_score); end
      tests++; if (lat !== LAT) begin fails++; $display("FAIL random_latency it=%0d got=%0d exp=%0d", it, lat, LAT); end
    end
  endtask

  task automatic test_same_cycle();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i <= NF; i++)
        mw[c][i] = (i == NF) ? 256 : 0;
    for (int k = 0; k < NF; k++) mx[k] = rnd16();
    load_all();
    pend_wr = 1'b1; pend_c = 7; pend_i = NF; pend_d = 32767;
    mw[7][NF] = 32767;
    model();
    run_job();
    tests++; if (got_pred !== exp_idx) begin fails++; $display("FAIL same_cycle_predict got=%0d exp=%0d", got_pred, exp_idx); end
    tests++; if (got_score !== exp_score) begin fails++; $display("FAIL same_cycle_score got=%0d exp=%0d", got_score, exp_score); end
  endtask

  task automatic test_handshake();
    int nvalid;
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < NF; i++) mw[c][i] = 0;
      mw[c][NF] = int'($urandom_range(20000)) - 10000;
    end
    for (int k = 0; k < NF; k++) mx[k] = rnd16();
    load_all();
    model();
    @(negedge clk);
    drive_feat();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvalid = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      start = (cyc == 3 || cyc == 11);
      wr_en = (cyc == 20);
      wr_class = 5'd3; wr_idx = 4'(NF); wr_data = 16'h7FFF;
      @(negedge clk);
      if (valid === 1'b1) begin
        nvalid++;
        got_pred = predict;
        got_score = score_max;
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
    tests++; if (nvalid !== 1) begin fails++; $display("FAIL handshake_valid_count got=%0d exp=1", nvalid); end
    tests++; if (got_pred !== exp_idx) begin fails++; $display("FAIL handshake_predict got=%0d exp=%0d", got_pred, exp_idx); end
    run_job();
    tests++; if (got_pred !== exp_idx) begin fails++; $display("FAIL handshake_rerun_predict got=%0d exp=%0d", got_pred, exp_idx); end
    tests++; if (got_score !== exp_score) begin fails++; $display("FAIL handshake_rerun_score got=%0d exp=%0d", got_score, exp_score); end
  endtask

  task automatic test_back_to_back();
    int n1, gap;
    @(negedge clk);
    drive_feat();
    start = 1'b1;
    n1 = 0;
    while (valid !== 1'b1 && n1 < 400) begin
      @(negedge clk);
      n1++;
    end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (valid !== 1'b1 && gap < 600);
    start = 1'b0;
    got_pred = predict;
    got_score = score_max;
    tests++; if (gap !== LAT + 2) begin fails++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, LAT + 2); end
    tests++; if (got_pred !== exp_idx) begin fails++; $display("FAIL b2b_predict got=%0d exp=%0d", got_pred, exp_idx); end
    tests++; if (got_score !== exp_score) begin fails++; $display("FAIL b2b_score got=%0d exp=%0d", got_score, exp_score); end
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_no_third_job busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int nvalid;
    for (int c = 0; c < NC; c++)
      for (int i = 0; i <= NF; i++)
        mw[c][i] = rnd16();
    for (int k = 0; k < NF; k++) mx[k] = rnd16();
    load_all();
    model();
    run_job();
    tests++; if (got_score !== exp_score) begin fails++; $display("FAIL rstmid_first_score got=%0d exp=%0d", got_score, exp_score); end
    @(negedge clk);
    drive_feat();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got=%b exp=0", valid); end
    tests++; if (predict !== 5'd0) begin fails++; $display("FAIL rstmid_predict got=%0d exp=0", predict); end
    tests++; if (score_max !== 40'sd0) begin fails++; $display("FAIL rstmid_score got=%0d exp=0", score_max); end
    @(negedge clk);
    rst = 1'b1;
    nvalid = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
    end
    tests++; if (nvalid !== 0) begin fails++; $display("FAIL rstmid_no_valid got=%0d exp=0", nvalid); end
    run_job();
    tests++; if (got_pred !== exp_idx) begin fails++; $display("FAIL rstmid_rerun_predict got=%0d exp=%0d", got_pred, exp_idx); end
    tests++; if (got_score !== exp_score) begin fails++; $display("FAIL rstmid_rerun_score got=%0d exp=%0d", got_score, exp_score); end
  endtask

  task automatic test_stress();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i <= NF; i++)
        mw[c][i] = (i == NF) ? 32767 : ((c == NC - 1) ? 32767 : -32768);
    for (int k = 0; k < NF; k++) mx[k] = 32767;
    load_all();
    model();
    run_job();
    tests++; if (got_pred !== NC - 1) begin fails++; $display("FAIL stress_predict got=%0d exp=%0d", got_pred, NC - 1); end
    tests++; if (got_score !== exp_score) begin fails++; $display("FAIL stress_score got=%0d exp=%0d", got_score, exp_score); end
    tests++; if (lat !== LAT) begin fails++; $display("FAIL stress_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_neg();
    test_tie();
    test_random();
    test_same_cycle();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_stress();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
